ifid_pipe_reg: RTL and testbench
================================

# ifid_pipe_reg

Parametrised IF/ID pipeline register for the fetch-to-decode boundary. It carries the fetched instruction and the incremented PC from the fetch stage to the decode stage. Compared with a plain clocked latch, it adds a valid/ready handshake on both sides, a two-entry skid buffer so that no combinational ready path crosses the stage, a synchronous flush that turns the stage into a bubble, and saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- INST_W, 16, instruction width in bits
- PC_W, 16, incremented-PC width in bits
- NOP_INST, 16'h0000 (INST_W bits), instruction word presented whenever the output is empty
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  fetch stage presents a valid instruction
- in_ready  out  1  stage can accept; registered (equals skid-empty)
- inst_in  in  INST_W  fetched instruction
- pc_in  in  PC_W  incremented PC from fetch
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode stage consumes this cycle (low = stall)
- inst_out  out  INST_W  instruction to decode
- pc_out  out  PC_W  incremented PC to decode
- flush  in  1  discard all held and incoming entries this cycle
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  cycles with flush=1, saturating

## Operation
- Storage is a main entry (drives the outputs) and a skid entry. Each entry holds a valid bit, an instruction and a PC.
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Main update, with flush=0:
  - if main is empty or consume: load main from skid if skid is valid, else from the input on accept, else clear main.
  - otherwise hold main.
- Skid update, with flush=0:
  - skid fills only when accept occurs while main stays occupied (main valid and no consume).
  - skid empties when main loads from it.
  - the skid can never be written while already valid, because in_ready=0 in that state.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush has priority over everything:
  - main and skid valid bits clear.
  - an input accepted in the same cycle is dropped.
  - a consume in the same cycle still counts as delivered to decode.
- Whenever main is invalid, inst_out=NOP_INST and pc_out=0. Data registers are written to these values on clear, flush and reset.
- Counters: each increments by 1 on its event, holds at 2^CNT_W-1, and clears only on reset.
- Reset (rst_n=0 at a clock edge): out_valid=0, in_ready=1, inst_out=NOP_INST, pc_out=0, skid empty, stall_cnt=0, flush_cnt=0. Reset overrides flush and all transfers.

## Timing
- Latency: an instruction accepted at edge N appears on outputs with out_valid=1 after edge N (usable in cycle N+1) when main was empty or consumed at N.
- Throughput: one instruction per cycle with out_ready held high. in_ready stays 1 throughout.
- Stall back-pressure:
  - first stalled accept goes to skid; in_ready=0 from the next cycle.
  - in_ready returns to 1 the cycle after the consume that drains the skid into main.
- in_ready, out_valid, inst_out and pc_out are register outputs with no combinational path from any input.
- Flush at edge N: out_valid=0 and in_ready=1 after N. A new accept in cycle N+1 gives out_valid=1 after N+1.
- Simultaneous flush and stall: flush wins. stall_cnt still increments for that cycle if out_valid=1 and out_ready=0.
- Reset mid-operation: all held entries are lost with no partial outputs; state after the edge equals the reset values above.

## Test plan
- Reset, then stream A=16'h1234/PC 2, B=16'h5678/PC 4, C/PC 6 with out_ready=1 -> each appears one cycle after accept, in order; in_ready stays 1.
- Hold out_ready=0 while streaming A, B, C -> main=A, skid=B, in_ready=0 from the cycle after B, C held at the input; stall_cnt increments every stalled cycle. Release out_ready -> A, B, C delivered back-to-back with no loss or duplication.
- Fill main and skid, assert flush for one cycle with in_valid=1 -> out_valid=0, inst_out=16'h0000, pc_out=0, in_ready=1, the input dropped, flush_cnt=1. The next accepted instruction is delivered normally.
- CNT_W=4, stall for 20 cycles -> stall_cnt reaches 15 and holds.
- Assert rst_n=0 for one edge while both entries are full and flush=1 -> all outputs at reset values and both counters 0.
- INST_W=32, PC_W=32, NOP_INST=32'h00000013 -> empty output shows 32'h00000013; the full 32-bit data passes intact.

Source files
------------

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: two-entry skid buffer (main + skid) with registered
// ready, synchronous flush, and saturating stall/flush event counters.
module ifid_pipe_reg #(
    parameter int unsigned       INST_W   = 16,
    parameter int unsigned       PC_W     = 16,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic accept;
    logic consume;
    logic main_free;

    // Ready depends only on the skid register, so no input reaches it combinationally.
    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign inst_out  = main_inst_q;
    assign pc_out    = main_pc_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    assign accept    = in_valid & ~skid_valid_q;
    assign consume   = main_valid_q & out_ready;
    assign main_free = ~main_valid_q | consume;

    // Next state of main and skid entries; flush clears both and drops any accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_inst_d  = main_inst_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_inst_d  = NOP_INST;
            main_pc_d    = '0;
            skid_valid_d = 1'b0;
            skid_inst_d  = NOP_INST;
            skid_pc_d    = '0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Skid holds the older entry; accept is impossible here (in_ready=0).
                main_valid_d = 1'b1;
                main_inst_d  = skid_inst_q;
                main_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
                skid_inst_d  = NOP_INST;
                skid_pc_d    = '0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_inst_d  = inst_in;
                main_pc_d    = pc_in;
            end else begin
                main_valid_d = 1'b0;
                main_inst_d  = NOP_INST;
                main_pc_d    = '0;
            end
        end else if (accept) begin
            // Main stays occupied; the skid is known empty because accept implies in_ready.
            skid_valid_d = 1'b1;
            skid_inst_d  = inst_in;
            skid_pc_d    = pc_in;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_inst_q  <= NOP_INST;
            main_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_inst_q  <= main_inst_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Bench for ifid_pipe_reg: a default 16-bit instance and a 32-bit instance with
// NOP 32'h13 and 4-bit counters share one stimulus and one FIFO-queue model.
module tb_ifid_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush;
    logic [31:0] inst_in, pc_in;

    logic        a_in_ready, a_out_valid;
    logic [15:0] a_inst_out, a_pc_out, a_stall_cnt, a_flush_cnt;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_inst_out, b_pc_out;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: up to two pending entries in arrival order, plus counters.
    logic [63:0] q[$];
    int          m_stall16, m_stall4, m_flush16, m_flush4;

    always #5 clk = ~clk;

    ifid_pipe_reg dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .inst_in   (inst_in[15:0]),
        .pc_in     (pc_in[15:0]),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .inst_out  (a_inst_out),
        .pc_out    (a_pc_out),
        .flush     (flush),
        .stall_cnt (a_stall_cnt),
        .flush_cnt (a_flush_cnt)
    );

    ifid_pipe_reg #(
        .INST_W   (32),
        .PC_W     (32),
        .NOP_INST (32'h0000_0013),
        .CNT_W    (4)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .inst_in   (inst_in),
        .pc_in     (pc_in),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .inst_out  (b_inst_out),
        .pc_out    (b_pc_out),
        .flush     (flush),
        .stall_cnt (b_stall_cnt),
        .flush_cnt (b_flush_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic        v;
        logic [31:0] ei, ep;
        v  = (q.size() > 0);
        ei = v ? q[0][63:32] : 32'h0;
        ep = v ? q[0][31:0]  : 32'h0;
        chk("a_out_valid", 64'(a_out_valid), 64'(v));
        chk("a_in_ready",  64'(a_in_ready),  64'(q.size() < 2));
        chk("a_inst_out",  64'(a_inst_out),  64'(ei[15:0]));
        chk("a_pc_out",    64'(a_pc_out),    64'(ep[15:0]));
        chk("a_stall_cnt", 64'(a_stall_cnt), 64'(m_stall16));
        chk("a_flush_cnt", 64'(a_flush_cnt), 64'(m_flush16));
        chk("b_out_valid", 64'(b_out_valid), 64'(v));
        chk("b_in_ready",  64'(b_in_ready),  64'(q.size() < 2));
        chk("b_inst_out",  64'(b_inst_out),  64'(v ? ei : 32'h0000_0013));
        chk("b_pc_out",    64'(b_pc_out),    64'(ep));
        chk("b_stall_cnt", 64'(b_stall_cnt), 64'(m_stall4));
        chk("b_flush_cnt", 64'(b_flush_cnt), 64'(m_flush4));
    endtask

    // Apply one cycle of inputs, advance the model over the edge, then compare.
    task automatic step(input logic rn, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic ordy, input logic fl);
        logic cons, acc;
        rst_n = rn; in_valid = iv; inst_in = inst; pc_in = pc; out_ready = ordy; flush = fl;
        if (!rn) begin
            q.delete();
            m_stall16 = 0; m_stall4 = 0; m_flush16 = 0; m_flush4 = 0;
        end else begin
            if (q.size() > 0 && !ordy) begin
                if (m_stall16 < 65535) m_stall16++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (fl) begin
                if (m_flush16 < 65535) m_flush16++;
                if (m_flush4 < 15) m_flush4++;
            end
            cons = (q.size() > 0) && ordy;
            acc  = iv && (q.size() < 2);
            if (fl) q.delete();
            else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back({inst, pc});
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        rn, iv;
        logic [31:0] inst, pc;
        logic        ordy, fl;
        logic        ev, er;
        logic [15:0] einst, epc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        inst_in = '0; pc_in = '0;
        m_stall16 = 0; m_stall4 = 0; m_flush16 = 0; m_flush4 = 0;

        //          rn    iv    inst           pc     ordy  fl    ev    er    einst     epc
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd0};
        // streaming with out_ready high
        vecs[1]  = '{1'b1, 1'b1, 32'h1234,     32'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 16'd2};
        vecs[2]  = '{1'b1, 1'b1, 32'h5678,     32'd4, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5678, 16'd4};
        vecs[3]  = '{1'b1, 1'b1, 32'h9abc,     32'd6, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9abc, 16'd6};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd0};
        // stall: A to main, B to skid, C held off, then drain
        vecs[5]  = '{1'b1, 1'b1, 32'h1234,     32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'd2};
        vecs[6]  = '{1'b1, 1'b1, 32'h5678,     32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'd2};
        vecs[7]  = '{1'b1, 1'b1, 32'h9abc,     32'd6, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 32'h9abc,     32'd6, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5678, 16'd4};
        vecs[9]  = '{1'b1, 1'b1, 32'h9abc,     32'd6, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9abc, 16'd6};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd0};
        // flush with both entries full and an input offered
        vecs[11] = '{1'b1, 1'b1, 32'h1234,     32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'd2};
        vecs[12] = '{1'b1, 1'b1, 32'h5678,     32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'd2};
        vecs[13] = '{1'b1, 1'b1, 32'hdead,     32'd8, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'd0};
        vecs[14] = '{1'b1, 1'b1, 32'hdead,     32'd8, 1'b1, 1'b0, 1'b1, 1'b1, 16'hdead, 16'd8};
        vecs[15] = '{1'b1, 1'b0, 32'h0,        32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rn, vecs[i].iv, vecs[i].inst, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_ready", i), 64'(a_in_ready),  64'(vecs[i].er));
            chk($sformatf("vec%0d_inst", i),  64'(a_inst_out),  64'(vecs[i].einst));
            chk($sformatf("vec%0d_pc", i),    64'(a_pc_out),    64'(vecs[i].epc));
            if (i == 13) chk("flush_cnt_after_flush", 64'(a_flush_cnt), 64'd1);
        end

        // 32-bit data path and NOP on empty output
        chk("b_empty_nop", 64'(b_inst_out), 64'h0000_0013);
        step(1'b1, 1'b1, 32'hcafe_f00d, 32'h8000_0004, 1'b0, 1'b0);
        chk("b_wide_inst", 64'(b_inst_out), 64'hcafe_f00d);
        chk("b_wide_pc",   64'(b_pc_out),   64'h8000_0004);

        // Stall long enough to saturate the 4-bit counter
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("b_stall_sat", 64'(b_stall_cnt), 64'd15);

        // Reset while both entries are full and flush is asserted
        step(1'b1, 1'b1, 32'h1111_2222, 32'h10, 1'b0, 1'b0);
        chk("full_before_rst", 64'(a_in_ready), 64'd0);
        step(1'b0, 1'b1, 32'h3333_4444, 32'h12, 1'b0, 1'b1);
        chk("rst_valid",     64'(a_out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(a_stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(b_flush_cnt), 64'd0);
        chk("rst_nop",       64'(b_inst_out),  64'h0000_0013);

        // Randomised traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, $urandom, $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
